// File: rtl/fu_retire_queue_if.sv
// Execution-unit result port and arbiter retirement port of fu_retire_queue.
// master = execution unit / arbiter side, slave = the queue.
interface fu_retire_queue_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int UNIT_W     = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush_i;
    logic                  result_valid_i;
    logic [DATA_WIDTH-1:0] result_i;
    logic                  accept_o;
    logic                  retire_en_i;
    logic [UNIT_W-1:0]     unit_retire_i;
    logic                  retirement_ready_o;
    logic [DATA_WIDTH-1:0] unit_result_o;
    logic [CNT_W-1:0]      count_o;

    modport master (
        output flush_i, result_valid_i, result_i, retire_en_i, unit_retire_i,
        input  accept_o, retirement_ready_o, unit_result_o, count_o
    );

    modport slave (
        input  flush_i, result_valid_i, result_i, retire_en_i, unit_retire_i,
        output accept_o, retirement_ready_o, unit_result_o, count_o
    );
endinterface

// File: rtl/fu_retire_queue.sv
// Per-functional-unit FIFO of completed results feeding the retirement arbiter.
// Optional FU_RETIRE_BYPASS_EN: an empty queue forwards result_i straight to the arbiter.
module fu_retire_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int UNIT_ID    = 0,
    parameter int UNIT_W     = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fu_retire_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic empty;
    logic accept;
    logic bypass;
    logic ready;
    logic grant;
    logic push;
    logic pop;

    assign empty  = (count_q == '0);
    assign accept = !rst_i && (count_q != CNT_W'(DEPTH));

`ifdef FU_RETIRE_BYPASS_EN
    assign bypass = empty && bus.result_valid_i && !rst_i && !bus.flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign ready = !empty || bypass;
    assign grant = bus.retire_en_i && (bus.unit_retire_i == UNIT_W'(UNIT_ID)) && ready;

    // A granted bypass consumes the incoming result, so neither push nor pop touches storage.
    assign push = bus.result_valid_i && accept && !(bypass && grant);
    assign pop  = grant && !bypass;

    assign bus.accept_o           = accept;
    assign bus.retirement_ready_o = ready;
    assign bus.count_o            = count_q;

    always_comb begin
        if (bypass) begin
            bus.unit_result_o = bus.result_i;
        end else if (empty) begin
            bus.unit_result_o = '0;
        end else begin
            bus.unit_result_o = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; only the pointers and count define valid entries.
    always_ff @(posedge clk_i) begin
        if (push && !bus.flush_i) begin
            mem_q[wr_ptr_q] <= bus.result_i;
        end
    end
endmodule

// File: tb/tb_fu_retire_queue.sv
// Directed self-checking bench for fu_retire_queue (UNIT_ID=2, DEPTH=4).
module tb_fu_retire_queue;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int UW    = 3;
    localparam int UID   = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fu_retire_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .UNIT_W(UW)) bus ();

    fu_retire_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .UNIT_ID   (UID),
        .UNIT_W    (UW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.flush_i        = 1'b0;
        bus.result_valid_i = 1'b0;
        bus.result_i       = '0;
        bus.retire_en_i    = 1'b0;
        bus.unit_retire_i  = '0;
    endtask

    task automatic push_one(input logic [DW-1:0] v);
        bus.result_valid_i = 1'b1;
        bus.result_i       = v;
        tick();
        bus.result_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.retirement_ready_o); end
        n_checks++; if (bus.accept_o !== 1'b0) begin n_fail++; $display("FAIL reset_accept got %b exp 0", bus.accept_o); end
        n_checks++; if (bus.unit_result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.unit_result_o); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.accept_o !== 1'b1) begin n_fail++; $display("FAIL release_accept got %b exp 1", bus.accept_o); end
    endtask

    task automatic test_fifo_order;
        logic [DW-1:0] exp_v [3] = '{64'hA1, 64'hA2, 64'hA3};
        push_one(64'hA1);
        push_one(64'hA2);
        push_one(64'hA3);
        #1;
        n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL fifo_count got %0d exp 3", bus.count_o); end
        bus.retire_en_i   = 1'b1;
        bus.unit_retire_i = UW'(UID);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.unit_result_o !== exp_v[i]) begin n_fail++; $display("FAIL fifo_head%0d got %h exp %h", i, bus.unit_result_o, exp_v[i]); end
            tick();
        end
        bus.retire_en_i = 1'b0;
        #1;
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL fifo_drained_ready got %b exp 0", bus.retirement_ready_o); end
    endtask

    task automatic test_full;
        logic [DW-1:0] exp_v [4] = '{64'hB1, 64'hB2, 64'hB3, 64'hFF};
        for (int i = 0; i < 4; i++) push_one(64'hB0 + 64'(i));
        bus.result_valid_i = 1'b1;
        bus.result_i       = 64'hFF;
        #1;
        n_checks++; if (bus.accept_o !== 1'b0) begin n_fail++; $display("FAIL full_accept got %b exp 0", bus.accept_o); end
        tick();
        tick();
        n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got %0d exp 4", bus.count_o); end
        n_checks++; if (bus.unit_result_o !== 64'hB0) begin n_fail++; $display("FAIL full_head got %h exp b0", bus.unit_result_o); end
        bus.retire_en_i   = 1'b1;
        bus.unit_retire_i = UW'(UID);
        tick();
        bus.retire_en_i = 1'b0;
        #1;
        n_checks++; if (bus.accept_o !== 1'b1) begin n_fail++; $display("FAIL after_pop_accept got %b exp 1", bus.accept_o); end
        tick();
        bus.result_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 3'd4) begin n_fail++; $display("FAIL refill_count got %0d exp 4", bus.count_o); end
        bus.retire_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.unit_result_o !== exp_v[i]) begin n_fail++; $display("FAIL full_drain%0d got %h exp %h", i, bus.unit_result_o, exp_v[i]); end
            tick();
        end
        bus.retire_en_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL full_drained_count got %0d exp 0", bus.count_o); end
    endtask

    task automatic test_back_to_back;
        push_one(64'hC0);
        push_one(64'hC1);
        bus.retire_en_i   = 1'b1;
        bus.unit_retire_i = UW'(UID);
        for (int i = 0; i < 6; i++) begin
            bus.result_valid_i = 1'b1;
            bus.result_i       = 64'hC2 + 64'(i);
            #1;
            n_checks++; if (bus.unit_result_o !== 64'hC0 + 64'(i)) begin n_fail++; $display("FAIL b2b_head%0d got %h exp %h", i, bus.unit_result_o, 64'hC0 + 64'(i)); end
            n_checks++; if (bus.count_o !== 3'd2) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 2", i, bus.count_o); end
            tick();
        end
        bus.result_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.unit_result_o !== 64'hC6) begin n_fail++; $display("FAIL b2b_tail0 got %h exp c6", bus.unit_result_o); end
        tick();
        n_checks++; if (bus.unit_result_o !== 64'hC7) begin n_fail++; $display("FAIL b2b_tail1 got %h exp c7", bus.unit_result_o); end
        tick();
        bus.retire_en_i = 1'b0;
        #1;
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_ready got %b exp 0", bus.retirement_ready_o); end
    endtask

    task automatic test_other_unit_and_flush;
        push_one(64'hD0);
        push_one(64'hD1);
        push_one(64'hD2);
        bus.retire_en_i   = 1'b1;
        bus.unit_retire_i = UW'(UID + 1);
        tick();
        bus.retire_en_i = 1'b0;
        n_checks++; if (bus.count_o !== 3'd3) begin n_fail++; $display("FAIL other_unit_count got %0d exp 3", bus.count_o); end
        n_checks++; if (bus.unit_result_o !== 64'hD0) begin n_fail++; $display("FAIL other_unit_head got %h exp d0", bus.unit_result_o); end
        bus.flush_i        = 1'b1;
        bus.result_valid_i = 1'b1;
        bus.result_i       = 64'hD3;
        tick();
        bus.flush_i        = 1'b0;
        bus.result_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", bus.count_o); end
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", bus.retirement_ready_o); end
        n_checks++; if (bus.accept_o !== 1'b1) begin n_fail++; $display("FAIL flush_accept got %b exp 1", bus.accept_o); end
    endtask

    task automatic test_mid_reset;
        push_one(64'hE0);
        push_one(64'hE1);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.accept_o !== 1'b0) begin n_fail++; $display("FAIL midrst_accept got %b exp 0", bus.accept_o); end
        tick();
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.count_o); end
        n_checks++; if (bus.unit_result_o !== 64'h0) begin n_fail++; $display("FAIL midrst_result got %h exp 0", bus.unit_result_o); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.accept_o !== 1'b1) begin n_fail++; $display("FAIL midrst_release_accept got %b exp 1", bus.accept_o); end
    endtask

    task automatic test_bypass;
        bus.result_valid_i = 1'b1;
        bus.result_i       = 64'h5C;
        bus.retire_en_i    = 1'b1;
        bus.unit_retire_i  = UW'(UID);
        #1;
`ifdef FU_RETIRE_BYPASS_EN
        n_checks++; if (bus.retirement_ready_o !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %b exp 1", bus.retirement_ready_o); end
        n_checks++; if (bus.unit_result_o !== 64'h5C) begin n_fail++; $display("FAIL bypass_result got %h exp 5c", bus.unit_result_o); end
        tick();
        idle();
        #1;
        n_checks++; if (bus.count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d exp 0", bus.count_o); end
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL bypass_after_ready got %b exp 0", bus.retirement_ready_o); end
`else
        n_checks++; if (bus.retirement_ready_o !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready got %b exp 0", bus.retirement_ready_o); end
        n_checks++; if (bus.unit_result_o !== 64'h0) begin n_fail++; $display("FAIL nobypass_result got %h exp 0", bus.unit_result_o); end
        tick();
        idle();
        #1;
        n_checks++; if (bus.count_o !== 3'd1) begin n_fail++; $display("FAIL nobypass_count got %0d exp 1", bus.count_o); end
        n_checks++; if (bus.retirement_ready_o !== 1'b1) begin n_fail++; $display("FAIL nobypass_next_ready got %b exp 1", bus.retirement_ready_o); end
        n_checks++; if (bus.unit_result_o !== 64'h5C) begin n_fail++; $display("FAIL nobypass_next_result got %h exp 5c", bus.unit_result_o); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_fifo_order();
        test_full();
        test_back_to_back();
        test_other_unit_and_flush();
        test_mid_reset();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
